// File: rtl/n64_pkg.sv
// Shared constants, command codes and state encoding
// for the N64 controller response path.
package n64_pkg;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam int CELL_CYCLES     = 8;
  localparam int LOW0_CYCLES     = 6;
  localparam int LOW1_CYCLES     = 2;
  localparam int STOP_LOW_CYCLES = 4;
  localparam int TURNAROUND      = 4;

  localparam logic [23:0] INFO_ID = 24'h050002;

  localparam int INFO_BITS = 24;
  localparam int POLL_BITS = 32;

  localparam int BTN_A     = 31;
  localparam int BTN_B     = 30;
  localparam int BTN_Z     = 29;
  localparam int BTN_START = 28;
  localparam int BTN_DU    = 27;
  localparam int BTN_DD    = 26;
  localparam int BTN_DL    = 25;
  localparam int BTN_DR    = 24;
  localparam int BTN_RST   = 23;
  localparam int BTN_L     = 21;
  localparam int BTN_R     = 20;
  localparam int BTN_CU    = 19;
  localparam int BTN_CD    = 18;
  localparam int BTN_CL    = 17;
  localparam int BTN_CR    = 16;
  localparam int BTN_X_MSB = 15;
  localparam int BTN_Y_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP
  } state_e;

endpackage

// File: rtl/n64_bit_cell_tx.sv
// One pulse-width-coded bit cell (or the short stop
// cell) on the open-drain line; oe_o is a flop output.
module n64_bit_cell_tx
  import n64_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic bit_i,
  input  logic stop_i,
  output logic oe_o,
  output logic fall_o,
  output logic cell_done_o
);

  localparam int CW = $clog2(CELL_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic          bit_q;
  logic          stop_q;
  logic          oe_q;

  logic [CW:0] nxt;
  logic [CW:0] low_len;
  logic [CW:0] last;
  logic        oe_d;

  always_comb begin
    nxt = {1'b0, cnt_q} + (CW+1)'(1);
    if (stop_q)
      low_len = (CW+1)'(STOP_LOW_CYCLES);
    else if (bit_q)
      low_len = (CW+1)'(LOW1_CYCLES);
    else
      low_len = (CW+1)'(LOW0_CYCLES);
    // stop cell ends as soon as its low phase does
    last = stop_q ? (CW+1)'(STOP_LOW_CYCLES - 1)
                  : (CW+1)'(CELL_CYCLES - 1);
    cell_done_o = active_q && ({1'b0, cnt_q} == last);
    oe_d = active_q && !cell_done_o && (nxt < low_len);
    fall_o = oe_q && !oe_d && !start_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      stop_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      bit_q    <= bit_i;
      stop_q   <= stop_i;
      oe_q     <= 1'b1;
    end else begin
      oe_q <= oe_d;
      if (cell_done_o)
        active_q <= 1'b0;
      else if (active_q)
        cnt_q <= nxt[CW-1:0];
    end
  end

  assign oe_o = oe_q;

endmodule

// File: rtl/n64_response_sequencer.sv
// Command decode, response latch and turnaround/stop
// sequencing for the fake N64 controller transmitter.
module n64_response_sequencer
  import n64_pkg::*;
(
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic [31:0] buttons,
  output logic        data_oe,
  output logic        busy,
  output logic        done,
  output logic        cmd_dropped
);

  localparam int TW = $clog2(TURNAROUND + 1);

  state_e        state_q;
  logic [31:0]   shreg_q;
  logic [5:0]    nbits_q;
  logic [5:0]    bit_cnt_q;
  logic [TW-1:0] turn_cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          drop_q;

  logic       is_info;
  logic       is_poll;
  logic       turn_last;
  logic       more;
  logic       cell_start;
  logic       cell_stop;
  logic       cell_bit;
  logic       cell_fall;
  logic       cell_done;
  logic [4:0] idx;

  always_comb begin
    is_info = (cmd_byte == CMD_INFO) ||
              (cmd_byte == CMD_RESET);
    is_poll = (cmd_byte == CMD_POLL);
    turn_last = (state_q == ST_TURN) &&
                (turn_cnt_q == TW'(TURNAROUND - 1));
    more = (bit_cnt_q + 6'd1) < nbits_q;
    cell_start = turn_last ||
                 ((state_q == ST_BIT_HIGH) && cell_done);
    cell_stop = (state_q == ST_BIT_HIGH) && !more;
    // response is left-aligned, so bit k sits at 31-k
    idx = turn_last ? 5'd31 : ~(bit_cnt_q[4:0] + 5'd1);
    cell_bit = shreg_q[idx];
  end

  n64_bit_cell_tx u_cell (
    .clk_i       (sample_clk),
    .rst_ni      (rst_n),
    .start_i     (cell_start),
    .bit_i       (cell_bit),
    .stop_i      (cell_stop),
    .oe_o        (data_oe),
    .fall_o      (cell_fall),
    .cell_done_o (cell_done)
  );

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      nbits_q    <= '0;
      bit_cnt_q  <= '0;
      turn_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= cmd_valid && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            unique case (1'b1)
              is_info: begin
                shreg_q    <= {INFO_ID, 8'h00};
                nbits_q    <= 6'(INFO_BITS);
                bit_cnt_q  <= '0;
                turn_cnt_q <= '0;
                busy_q     <= 1'b1;
                state_q    <= ST_TURN;
              end
              is_poll: begin
                shreg_q    <= buttons;
                nbits_q    <= 6'(POLL_BITS);
                bit_cnt_q  <= '0;
                turn_cnt_q <= '0;
                busy_q     <= 1'b1;
                state_q    <= ST_TURN;
              end
              default: drop_q <= 1'b1;
            endcase
          end
        end
        ST_TURN: begin
          if (turn_last)
            state_q <= ST_BIT_LOW;
          else
            turn_cnt_q <= turn_cnt_q + 1'b1;
        end
        ST_BIT_LOW: begin
          if (cell_fall)
            state_q <= ST_BIT_HIGH;
        end
        ST_BIT_HIGH: begin
          if (cell_done) begin
            if (more) begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              state_q   <= ST_BIT_LOW;
            end else begin
              bit_cnt_q <= nbits_q;
              state_q   <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (cell_done) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_dropped = drop_q;

endmodule

// File: tb/tb_n64_response_sequencer.sv
// Scoreboard bench: stimulus queues expected responses,
// a negedge monitor checks each one when done pulses.
module tb_n64_response_sequencer;

  localparam int T    = 4;
  localparam int CELL = 8;
  localparam int LOGN = 32768;

  logic        sample_clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [31:0] buttons;
  logic        data_oe;
  logic        busy;
  logic        done;
  logic        cmd_dropped;

  typedef struct {
    int          n;
    logic [31:0] d;
    int          nb;
  } resp_t;

  resp_t resp_q[$];
  int    drop_q[$];
  bit    oe_log[LOGN];
  bit    busy_log[LOGN];

  int cyc       = 0;
  int errors    = 0;
  int checks    = 0;
  int free_from = 0;
  int last_end  = 0;

  n64_response_sequencer dut (
    .sample_clk  (sample_clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .buttons     (buttons),
    .data_oe     (data_oe),
    .busy        (busy),
    .done        (done),
    .cmd_dropped (cmd_dropped)
  );

  always #5 sample_clk = ~sample_clk;

  always @(posedge sample_clk) cyc <= cyc + 1;

  // line level after edge t for a response accepted at edge r.n
  function automatic bit exp_oe(int t, resp_t r);
    int rel;
    int k;
    rel = t - r.n - T;
    if (rel < 0) return 1'b0;
    k = rel / CELL;
    if (k < r.nb)
      return (rel % CELL) < (r.d[r.nb-1-k] ? 2 : 6);
    return (rel - CELL * r.nb) < 4;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge sample_clk) begin
    resp_t r;
    int    dn;
    int    bad_oe;
    int    bad_busy;
    int    bad_idle;
    if (!rst_n) begin
      last_end = cyc;
    end else if (cyc < LOGN) begin
      oe_log[cyc]   = data_oe;
      busy_log[cyc] = busy;
      if (done) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done at cycle %0d", cyc);
        end else begin
          r = resp_q.pop_front();
          bad_oe   = 0;
          bad_busy = 0;
          bad_idle = 0;
          for (int t = last_end + 1; t <= r.n; t++)
            if (oe_log[t]) bad_idle++;
          for (int t = r.n + 1; t <= cyc; t++) begin
            if (oe_log[t] != exp_oe(t, r)) bad_oe++;
            if (busy_log[t] != (t < cyc)) bad_busy++;
          end
          check("done_cycle", cyc, r.n + T + CELL * r.nb + 4);
          check("waveform_errs", bad_oe, 0);
          check("busy_errs", bad_busy, 0);
          check("idle_line_errs", bad_idle, 0);
        end
        last_end = cyc;
      end
      if (cmd_dropped) begin
        if (drop_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_drop at cycle %0d", cyc);
        end else begin
          dn = drop_q.pop_front();
          checks++;
          if (!(cyc == dn || cyc == dn + 1)) begin
            errors++;
            $display("FAIL drop_timing: got cycle %0d required %0d or %0d",
                     cyc, dn, dn + 1);
          end
        end
      end
    end
  end

  // present a command so that it is sampled at edge e
  task automatic issue_at(input int e, input logic [7:0] b,
                          input logic [31:0] btn,
                          input logic [31:0] post_btn,
                          output int n);
    resp_t r;
    do @(negedge sample_clk); while (cyc < e - 1);
    n = cyc + 1;
    cmd_valid = 1'b1;
    cmd_byte  = b;
    buttons   = btn;
    if ((b == 8'h00 || b == 8'h01 || b == 8'hFF) &&
        n >= free_from) begin
      r.n  = n;
      r.nb = (b == 8'h01) ? 32 : 24;
      r.d  = (b == 8'h01) ? btn : 32'h0005_0002;
      resp_q.push_back(r);
      free_from = n + T + CELL * r.nb + 4 + 1;
    end else begin
      drop_q.push_back(n);
    end
    @(negedge sample_clk);
    cmd_valid = 1'b0;
    cmd_byte  = 8'($urandom);
    buttons   = post_btn;
  endtask

  task automatic wait_idle();
    do @(negedge sample_clk); while (cyc < free_from + 2);
  endtask

  initial begin
    int    n;
    int    m;
    int    sel;
    logic [7:0] b;
    resp_t r;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    buttons   = 32'h0;
    repeat (3) @(negedge sample_clk);
    check("reset_outputs", {data_oe, busy, done, cmd_dropped}, 0);
    rst_n = 1'b1;
    free_from = 0;

    issue_at(cyc + 10, 8'h00, 32'hFFFF_FFFF, 32'h0, n);
    wait_idle();

    issue_at(cyc + 3, 8'h01, 32'h8000_7F81, 32'h0, n);
    wait_idle();

    issue_at(cyc + 3, 8'h01, 32'h8000_7F81, 32'hFFFF_FFFF, n);
    issue_at(n + 50, 8'h01, 32'h0, 32'h1234_5678, m);
    wait_idle();
    issue_at(cyc + 4, 8'h42, 32'h0, 32'h0, n);
    wait_idle();

    issue_at(cyc + 3, 8'h00, 32'h0, 32'h0, n);
    m = n + T + CELL * 24 + 4;
    issue_at(m, 8'h01, 32'hA5A5_A5A5, 32'h0, n);
    issue_at(m + 1, 8'hFF, 32'h0, 32'h0, n);
    wait_idle();

    issue_at(cyc + 3, 8'h01, 32'h8000_7F81, 32'h0, n);
    r = resp_q[0];
    while (cyc < n + 119) @(negedge sample_clk);
    @(posedge sample_clk);
    #1;
    check("pre_reset_oe", data_oe, exp_oe(n + 120, r));
    rst_n = 1'b0;
    #1;
    check("async_release", {data_oe, busy}, 0);
    resp_q.delete();
    free_from = 0;
    repeat (2) @(negedge sample_clk);
    check("in_reset_outputs", {data_oe, busy, done, cmd_dropped}, 0);
    rst_n = 1'b1;
    issue_at(cyc + 3, 8'hFF, $urandom, $urandom, n);
    wait_idle();

    for (int i = 0; i < 14; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: b = 8'h00;
        1: b = 8'h01;
        2: b = 8'hFF;
        3: b = 8'h01;
        default: b = 8'($urandom);
      endcase
      issue_at(cyc + 2 + $urandom_range(0, 280), b,
               $urandom, $urandom, n);
    end

    wait_idle();
    repeat (5) @(negedge sample_clk);
    check("pending_responses", resp_q.size(), 0);
    check("pending_drops", drop_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n64_response_sequencer.md
Name: n64_response_sequencer

Overview:
- Controller-side transmit sequencer for the fake N64 controller, clocked by the 2 MHz sample_clk domain that async_to_sync produces.
- Accepts a decoded console command byte and selects the response: identity/info or button poll.
- Serialises the response MSB-first onto the one-wire N64 line as open-drain pulse-width-coded bit cells, followed by a stop bit.
- Owns line direction: the line is never driven except while responding.

Parameters:
- CELL_CYCLES, 8, sample_clk cycles per bit cell (4 us at 2 MHz).
- LOW0_CYCLES, 6, low-phase length of a '0' cell.
- LOW1_CYCLES, 2, low-phase length of a '1' cell.
- STOP_LOW_CYCLES, 4, low length of the stop bit; the line is released afterwards.
- TURNAROUND, 4, cycles from command acceptance to the first driven low (minimum 1).
- INFO_ID, 24'h050002, identity response for commands 0x00 and 0xFF.

Ports:
- sample_clk, input, 1, 2 MHz system clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, single-cycle strobe: cmd_byte holds a complete command.
- cmd_byte, input, 8, decoded console command.
- buttons, input, 32, live controller state in N64 poll order (A,B,Z,St,dU,dD,dL,dR,rst,0,L,R,cU,cD,cL,cR,X[8],Y[8]).
- data_oe, output, 1, 1 = pull the N64 line low; 0 = release (pull-up).
- busy, output, 1, high from acceptance until the line is released after the stop bit.
- done, output, 1, one-cycle pulse when a response completes.
- cmd_dropped, output, 1, one-cycle pulse when cmd_valid is ignored.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; data_oe=0, busy=0, done=0, cmd_dropped=0; counters and shift register cleared. Reset mid-response releases the line immediately.
- States: IDLE -> TURN -> BIT_LOW -> BIT_HIGH -> (next bit or STOP) -> IDLE.
- IDLE, cmd_valid sampled at edge N:
  - 0x00 or 0xFF: load INFO_ID, nbits=24.
  - 0x01: latch buttons, nbits=32. The shift register is frozen for the whole response.
  - Any other value: remain IDLE, pulse cmd_dropped at N+1.
  - Valid command: busy=1 from edge N+1.
- TURN: counts TURNAROUND cycles. data_oe rises at edge N+TURNAROUND.
- Bit k (k=0..nbits-1, MSB first):
  - Low phase starts at edge N+TURNAROUND+CELL_CYCLES*k.
  - data_oe is held for LOW1_CYCLES ('1') or LOW0_CYCLES ('0'), then released for the rest of the cell.
- STOP:
  - Starts at edge S = N+TURNAROUND+CELL_CYCLES*nbits; data_oe=1 for STOP_LOW_CYCLES.
  - At edge S+STOP_LOW_CYCLES: data_oe=0, busy=0, done=1 for one cycle, state=IDLE.
- A new command may be accepted on the edge after done.
- cmd_valid while busy: ignored, cmd_dropped pulses; the in-flight response is unaffected.
- cmd_valid coinciding with the done edge: ignored (busy is still 1 that cycle).
- Changes on buttons during a response have no effect.
- Cell counter width is clog2(CELL_CYCLES). Bit counter is 6 bits and saturates at nbits.
- data_oe is registered and glitch-free.

Decomposition:
- Shared package n64_pkg:
  - Command codes CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF.
  - Default timing constants.
  - State enum.
  - Button bit-index constants.
- One natural sub-module: n64_bit_cell_tx. It takes a bit plus a start strobe and produces the low/high cell waveform and cell_done. The sequencer handles only command decode, the shift register and stop/turnaround.

Test Plan:
- INFO: cmd_byte=0x00 at edge 100.
  - data_oe rises at edge 104.
  - Bits follow 0x050002; the first cell is a '0' (6 low, 2 high).
  - Stop bit low at edges 296–299; busy and data_oe fall and done pulses at edge 300.
- POLL: buttons=32'h8000_7F81, cmd 0x01 at edge 0.
  - Cell 0 is '1' (2 low).
  - Cell 17 is '1', cell 16 is '0'.
  - Stop bit at edges 260–263; done at edge 264.
- Buttons toggled to 0 mid-poll -> waveform identical to the latched 32'h8000_7F81.
- cmd 0x42 in IDLE -> cmd_dropped pulse, data_oe and busy stay 0. cmd 0x01 at edge 50 of an active response -> cmd_dropped, no waveform change.
- rst_n low at edge 120 of a poll, while data_oe=1 -> data_oe=0 immediately (asynchronous). After release, idle. A 0xFF command then yields a full INFO response.
- Back-to-back: second cmd_valid on the done edge is dropped. cmd_valid one cycle later is accepted, and data_oe rises TURNAROUND cycles after it.
